// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the RAM access controller: FSM states, size codes,
// read/write polarity and requester port IDs.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_ACK     = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    localparam logic [1:0] MS_BYTE = 2'b00;
    localparam logic [1:0] MS_HALF = 2'b01;
    localparam logic [1:0] MS_WORD = 2'b10;
    localparam int         MS_SIGN = 2;

    localparam logic RW_READ = 1'b1;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Size code 11 is undefined and is rejected like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] ms, input logic [1:0] addr);
        case (ms)
            MS_BYTE: return 1'b0;
            MS_HALF: return addr[0];
            MS_WORD: return (addr != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way arbiter between fetch (I) and data (D) requesters with a last-grant
// pointer; FIXED_PRIO=1 makes D win every conflict.
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_upd,
    input  logic i_upd_port,
    output logic o_gnt_valid,
    output logic o_gnt_port
);

    logic r_last;

    // Pointer starts at D so the fetch port wins the first tie after reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last <= PORT_D;
        end else if (i_upd) begin
            r_last <= i_upd_port;
        end
    end

    always_comb begin
        o_gnt_valid = i_req_i | i_req_d;
        o_gnt_port  = i_req_d ? PORT_D : PORT_I;
        if (FIXED_PRIO == 0 && i_req_i && i_req_d) begin
            o_gnt_port = (r_last == PORT_D) ? PORT_I : PORT_D;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MOV/MOC/MOCoff sequencer for the 256x8 RAM serving a fetch and a data port.
// Define MEM_TIMEOUT_EN to add a MOC watchdog that ends WAIT with an error Ack.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int FIXED_PRIO  = 0,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        I_Req,
    input  logic [31:0] I_Addr,
    output logic        I_Ack,
    output logic        I_Err,
    output logic [31:0] I_Rdata,
    input  logic        D_Req,
    input  logic        D_RW,
    input  logic [2:0]  D_MS,
    input  logic [31:0] D_Addr,
    input  logic [31:0] D_Wdata,
    output logic        D_Ack,
    output logic        D_Err,
    output logic [31:0] D_Rdata,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [2:0]  MS_2_0,
    output logic [31:0] MemAddress,
    output logic [31:0] MemDataIn,
    output logic        MOCoff,
    input  logic        MOC,
    input  logic [31:0] MemDataOut,
    output logic        Busy
);

    state_t      r_state;
    state_t      w_next;
    logic        r_port;
    logic        r_rw;
    logic [2:0]  r_ms;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_gnt_valid;
    logic        w_gnt_port;
    logic        w_upd;
    logic        w_start;
    logic        w_misalign;
    logic        w_sel_rw;
    logic [2:0]  w_sel_ms;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_to_hit;
    logic        w_to_err;
    logic        w_ack;
    logic        w_err;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_to_err;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt    <= '0;
            r_to_err <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_cnt    <= '0;
            r_to_err <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_to_hit) r_to_err <= 1'b1;
        end
    end

    assign w_to_hit = (r_state == ST_WAIT) && !MOC && (r_cnt == CNT_W'(MOC_TIMEOUT - 1));
    assign w_to_err = r_to_err;
`else
    assign w_to_hit = 1'b0;
    assign w_to_err = 1'b0;
`endif

    mem_rr_arbiter #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .i_req_i    (I_Req),
        .i_req_d    (D_Req),
        .i_upd      (w_upd),
        .i_upd_port (r_port),
        .o_gnt_valid(w_gnt_valid),
        .o_gnt_port (w_gnt_port)
    );

    // Fetches are always unsigned word reads regardless of the data port inputs.
    always_comb begin
        w_sel_rw           = RW_READ;
        w_sel_ms           = '0;
        w_sel_ms[1:0]      = MS_WORD;
        w_sel_ms[MS_SIGN]  = 1'b0;
        w_sel_addr         = I_Addr;
        w_sel_wdata        = '0;
        if (w_gnt_port == PORT_D) begin
            w_sel_rw    = D_RW;
            w_sel_ms    = D_MS;
            w_sel_addr  = D_Addr;
            w_sel_wdata = D_Wdata;
        end
        w_misalign = is_misaligned(w_sel_ms[1:0], w_sel_addr[1:0]);
    end

    // A stale MOC in IDLE is cleared first; no grant is made that cycle.
    assign w_start = (r_state == ST_IDLE) && !MOC && w_gnt_valid;
    assign w_upd   = (r_state == ST_ACK) || (r_state == ST_ERR);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        MOV    = 1'b0;
        MOCoff = 1'b0;
        w_ack  = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                MOCoff = MOC && Reset_n;
                if (w_start) w_next = w_misalign ? ST_ERR : ST_WAIT;
            end
            ST_WAIT: begin
                MOV = 1'b1;
                if (MOC || w_to_hit) w_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                MOCoff = 1'b1;
                w_next = ST_ACK;
            end
            ST_ACK: begin
                w_ack  = 1'b1;
                w_err  = w_to_err;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                w_ack  = 1'b1;
                w_err  = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        I_Ack = w_ack && (r_port == PORT_I);
        I_Err = w_err && (r_port == PORT_I);
        D_Ack = w_ack && (r_port == PORT_D);
        D_Err = w_err && (r_port == PORT_D);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_port    <= PORT_I;
            r_rw      <= 1'b0;
            r_ms      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_start) begin
                r_port  <= w_gnt_port;
                r_rw    <= w_sel_rw;
                r_ms    <= w_sel_ms;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state == ST_WAIT && MOC && r_rw == RW_READ) begin
                if (r_port == PORT_I) r_i_rdata <= MemDataOut;
                else                  r_d_rdata <= MemDataOut;
            end
        end
    end

    assign ReadWrite  = r_rw;
    assign MS_2_0     = r_ms;
    assign MemAddress = r_addr;
    assign MemDataIn  = r_wdata;
    assign I_Rdata    = r_i_rdata;
    assign D_Rdata    = r_d_rdata;
    assign Busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: round-robin instance plus a fixed-priority
// instance; the MOC/MemDataOut RAM side is driven step by step.
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        I_Req = 1'b0;
    logic [31:0] I_Addr = '0;
    logic        I_Ack, I_Err;
    logic [31:0] I_Rdata;
    logic        D_Req = 1'b0;
    logic        D_RW = 1'b0;
    logic [2:0]  D_MS = '0;
    logic [31:0] D_Addr = '0;
    logic [31:0] D_Wdata = '0;
    logic        D_Ack, D_Err;
    logic [31:0] D_Rdata;
    logic        MOV, ReadWrite, MOCoff, Busy;
    logic [2:0]  MS_2_0;
    logic [31:0] MemAddress, MemDataIn;
    logic        MOC = 1'b0;
    logic [31:0] MemDataOut = '0;

    logic        fp_i_req = 1'b0, fp_d_req = 1'b0, fp_moc = 1'b0;
    logic        fp_i_ack, fp_i_err, fp_d_ack, fp_d_err;
    logic [31:0] fp_i_rdata, fp_d_rdata, fp_addr, fp_wdata;
    logic        fp_mov, fp_rw, fp_mocoff, fp_busy;
    logic [2:0]  fp_ms;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.FIXED_PRIO(0), .MOC_TIMEOUT(8)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .I_Req(I_Req), .I_Addr(I_Addr), .I_Ack(I_Ack), .I_Err(I_Err), .I_Rdata(I_Rdata),
        .D_Req(D_Req), .D_RW(D_RW), .D_MS(D_MS), .D_Addr(D_Addr), .D_Wdata(D_Wdata),
        .D_Ack(D_Ack), .D_Err(D_Err), .D_Rdata(D_Rdata),
        .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0), .MemAddress(MemAddress),
        .MemDataIn(MemDataIn), .MOCoff(MOCoff), .MOC(MOC), .MemDataOut(MemDataOut), .Busy(Busy)
    );

    mem_access_ctrl #(.FIXED_PRIO(1), .MOC_TIMEOUT(8)) u_fp (
        .Clk(Clk), .Reset_n(Reset_n),
        .I_Req(fp_i_req), .I_Addr(I_Addr), .I_Ack(fp_i_ack), .I_Err(fp_i_err), .I_Rdata(fp_i_rdata),
        .D_Req(fp_d_req), .D_RW(D_RW), .D_MS(D_MS), .D_Addr(D_Addr), .D_Wdata(D_Wdata),
        .D_Ack(fp_d_ack), .D_Err(fp_d_err), .D_Rdata(fp_d_rdata),
        .MOV(fp_mov), .ReadWrite(fp_rw), .MS_2_0(fp_ms), .MemAddress(fp_addr),
        .MemDataIn(fp_wdata), .MOCoff(fp_mocoff), .MOC(fp_moc), .MemDataOut(MemDataOut), .Busy(fp_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // From WAIT: return MOC with data, step through RELEASE, land in ACK.
    task automatic serve(input logic [31:0] data);
        MOC = 1'b1;
        MemDataOut = data;
        tick();
        chk("release_mocoff", {31'd0, MOCoff}, 32'd1);
        chk("release_mov", {31'd0, MOV}, 32'd0);
        MOC = 1'b0;
        tick();
    endtask

    task automatic fp_serve(input logic [31:0] data);
        fp_moc = 1'b1;
        MemDataOut = data;
        tick();
        chk("fp_release_mocoff", {31'd0, fp_mocoff}, 32'd1);
        fp_moc = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_mov", {31'd0, MOV}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_mocoff", {31'd0, MOCoff}, 32'd0);
        chk("rst_i_ack", {31'd0, I_Ack}, 32'd0);
        chk("rst_d_ack", {31'd0, D_Ack}, 32'd0);
        chk("rst_i_rdata", I_Rdata, 32'd0);
        chk("rst_d_rdata", D_Rdata, 32'd0);
        Reset_n = 1'b1;

        // Fetch with MOC two cycles after MOV
        I_Addr = 32'h10;
        I_Req = 1'b1;
        tick();
        chk("f_mov", {31'd0, MOV}, 32'd1);
        chk("f_addr", MemAddress, 32'h10);
        chk("f_rw", {31'd0, ReadWrite}, 32'd1);
        chk("f_ms", {29'd0, MS_2_0}, 32'd2);
        chk("f_busy", {31'd0, Busy}, 32'd1);
        tick();
        chk("f_mov_hold", {31'd0, MOV}, 32'd1);
        chk("f_no_early_ack", {31'd0, I_Ack}, 32'd0);
        MOC = 1'b1;
        MemDataOut = 32'hE3A00001;
        tick();
        chk("f_mocoff", {31'd0, MOCoff}, 32'd1);
        chk("f_mov_low", {31'd0, MOV}, 32'd0);
        chk("f_ack_not_yet", {31'd0, I_Ack}, 32'd0);
        MOC = 1'b0;
        tick();
        chk("f_ack", {31'd0, I_Ack}, 32'd1);
        chk("f_err", {31'd0, I_Err}, 32'd0);
        chk("f_rdata", I_Rdata, 32'hE3A00001);
        chk("f_mocoff_once", {31'd0, MOCoff}, 32'd0);
        I_Req = 1'b0;
        tick();
        chk("f_ack_pulse", {31'd0, I_Ack}, 32'd0);
        chk("f_idle", {31'd0, Busy}, 32'd0);

        // Contention after reset: I first, then D, then a second tie
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        I_Addr = 32'h40;
        D_Addr = 32'h80;
        D_RW = 1'b1;
        D_MS = 3'b010;
        I_Req = 1'b1;
        D_Req = 1'b1;
        tick();
        chk("c1_first_i", MemAddress, 32'h40);
        serve(32'hA5A5A5A5);
        chk("c1_i_ack", {31'd0, I_Ack}, 32'd1);
        chk("c1_d_wait", {31'd0, D_Ack}, 32'd0);
        chk("c1_i_rdata", I_Rdata, 32'hA5A5A5A5);
        I_Req = 1'b0;
        tick();
        chk("c1_idle", {31'd0, Busy}, 32'd0);
        tick();
        chk("c1_then_d", MemAddress, 32'h80);
        serve(32'h12345678);
        chk("c1_d_ack", {31'd0, D_Ack}, 32'd1);
        chk("c1_d_rdata", D_Rdata, 32'h12345678);
        chk("c1_i_rdata_kept", I_Rdata, 32'hA5A5A5A5);
        D_Req = 1'b0;
        tick();
        I_Addr = 32'h44;
        D_Addr = 32'h84;
        I_Req = 1'b1;
        D_Req = 1'b1;
        tick();
        chk("c2_first_i", MemAddress, 32'h44);
        serve(32'h11111111);
        chk("c2_i_ack", {31'd0, I_Ack}, 32'd1);
        I_Req = 1'b0;
        tick();
        tick();
        chk("c2_then_d", MemAddress, 32'h84);
        serve(32'h22222222);
        chk("c2_d_ack", {31'd0, D_Ack}, 32'd1);
        chk("c2_d_rdata", D_Rdata, 32'h22222222);
        D_Req = 1'b0;
        tick();

        // Fixed priority: D wins every tie
        fp_i_req = 1'b1;
        fp_d_req = 1'b1;
        tick();
        chk("fp_first_d", fp_addr, 32'h84);
        fp_serve(32'h33333333);
        chk("fp_d_ack", {31'd0, fp_d_ack}, 32'd1);
        chk("fp_i_wait", {31'd0, fp_i_ack}, 32'd0);
        chk("fp_d_rdata", fp_d_rdata, 32'h33333333);
        tick();
        tick();
        chk("fp_again_d", fp_addr, 32'h84);
        fp_serve(32'h44444444);
        chk("fp_d_ack2", {31'd0, fp_d_ack}, 32'd1);
        fp_d_req = 1'b0;
        tick();
        tick();
        chk("fp_then_i", fp_addr, 32'h44);
        fp_serve(32'h55555555);
        chk("fp_i_ack", {31'd0, fp_i_ack}, 32'd1);
        chk("fp_i_rdata", fp_i_rdata, 32'h55555555);
        fp_i_req = 1'b0;
        tick();

        // Misaligned halfword store
        D_RW = 1'b0;
        D_MS = 3'b001;
        D_Addr = 32'h21;
        D_Wdata = 32'h0000BEEF;
        D_Req = 1'b1;
        tick();
        chk("sh_mis_ack", {31'd0, D_Ack}, 32'd1);
        chk("sh_mis_err", {31'd0, D_Err}, 32'd1);
        chk("sh_mis_mov", {31'd0, MOV}, 32'd0);
        chk("sh_mis_rdata", D_Rdata, 32'h22222222);
        D_Req = 1'b0;
        tick();
        chk("sh_mis_ack_pulse", {31'd0, D_Ack}, 32'd0);
        chk("sh_mis_mov2", {31'd0, MOV}, 32'd0);

        // Aligned halfword store
        D_Addr = 32'h22;
        D_Req = 1'b1;
        tick();
        chk("sh_mov", {31'd0, MOV}, 32'd1);
        chk("sh_wdata", MemDataIn, 32'h0000BEEF);
        chk("sh_rw", {31'd0, ReadWrite}, 32'd0);
        chk("sh_ms", {29'd0, MS_2_0}, 32'd1);
        chk("sh_addr", MemAddress, 32'h22);
        serve(32'hDEADDEAD);
        chk("sh_ack", {31'd0, D_Ack}, 32'd1);
        chk("sh_err", {31'd0, D_Err}, 32'd0);
        chk("sh_rdata_kept", D_Rdata, 32'h22222222);
        D_Req = 1'b0;
        tick();

        // Undefined size code and misaligned word
        D_RW = 1'b1;
        D_MS = 3'b011;
        D_Addr = 32'h0;
        D_Req = 1'b1;
        tick();
        chk("ms11_err", {31'd0, D_Err}, 32'd1);
        chk("ms11_ack", {31'd0, D_Ack}, 32'd1);
        D_Req = 1'b0;
        tick();
        D_MS = 3'b010;
        D_Addr = 32'h2;
        D_Req = 1'b1;
        tick();
        chk("word_mis_err", {31'd0, D_Err}, 32'd1);
        chk("word_mis_mov", {31'd0, MOV}, 32'd0);
        D_Req = 1'b0;
        tick();

        // Signed byte load
        D_MS = 3'b100;
        D_Addr = 32'h3;
        D_Req = 1'b1;
        tick();
        chk("sb_ms", {29'd0, MS_2_0}, 32'd4);
        chk("sb_addr", MemAddress, 32'h3);
        chk("sb_rw", {31'd0, ReadWrite}, 32'd1);
        serve(32'hFFFFFF80);
        chk("sb_ack", {31'd0, D_Ack}, 32'd1);
        chk("sb_rdata", D_Rdata, 32'hFFFFFF80);
        D_Req = 1'b0;
        tick();

        // Reset during WAIT, then stale MOC cleared before serving
        I_Addr = 32'h50;
        I_Req = 1'b1;
        tick();
        chk("rw_mov", {31'd0, MOV}, 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rw_async_mov", {31'd0, MOV}, 32'd0);
        chk("rw_async_busy", {31'd0, Busy}, 32'd0);
        chk("rw_no_ack", {31'd0, I_Ack}, 32'd0);
        MOC = 1'b1;
        tick();
        chk("rw_rst_mocoff", {31'd0, MOCoff}, 32'd0);
        chk("rw_rst_ack", {31'd0, I_Ack}, 32'd0);
        Reset_n = 1'b1;
        #1;
        chk("rw_stale_mocoff", {31'd0, MOCoff}, 32'd1);
        chk("rw_stale_busy", {31'd0, Busy}, 32'd0);
        tick();
        chk("rw_no_grant", {31'd0, Busy}, 32'd0);
        chk("rw_no_mov", {31'd0, MOV}, 32'd0);
        MOC = 1'b0;
        tick();
        chk("rw_serve_mov", {31'd0, MOV}, 32'd1);
        chk("rw_serve_addr", MemAddress, 32'h50);
        serve(32'h50505050);
        chk("rw_ack", {31'd0, I_Ack}, 32'd1);
        chk("rw_rdata", I_Rdata, 32'h50505050);
        I_Req = 1'b0;
        tick();

`ifdef MEM_TIMEOUT_EN
        // Watchdog: MOC never returned
        D_MS = 3'b010;
        D_Addr = 32'h8;
        D_Req = 1'b1;
        tick();
        chk("to_mov_0", {31'd0, MOV}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("to_mov_n", {31'd0, MOV}, 32'd1);
        end
        tick();
        chk("to_mov_end", {31'd0, MOV}, 32'd0);
        chk("to_mocoff", {31'd0, MOCoff}, 32'd1);
        tick();
        chk("to_ack", {31'd0, D_Ack}, 32'd1);
        chk("to_err", {31'd0, D_Err}, 32'd1);
        chk("to_rdata", D_Rdata, 32'hFFFFFF80);
        D_Req = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
